// File: rtl/dispatch_queue.sv
// dispatch_queue: in-order renamed-instruction FIFO dispatching up to DISPATCH_WIDTH
// instructions per cycle to per-FU reservation stations, with parallel ROB allocation.
package dispatch_pkg;
    localparam logic [1:0] FU_ALU = 2'd0, FU_BRANCH = 2'd1, FU_LSU = 2'd2;
    typedef struct packed {
        logic [1:0]  fu_type;
        logic        is_branch;
        logic [4:0]  rob_tag;
        logic [31:0] payload;
    } renamed_instr_t;
endpackage

module dispatch_queue
    import dispatch_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int DISPATCH_WIDTH = 2,
    parameter int NUM_RS = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  renamed_instr_t             instr_in,
    input  logic                       valid_in,
    output logic                       ready_out,
    input  logic                       flush,
    input  logic [NUM_RS-1:0]          rs_full,
    output logic [NUM_RS-1:0]          dispatch_en,
    output renamed_instr_t             dispatch_instr [NUM_RS],
    input  logic [$clog2(DEPTH):0]     rob_free,
    output logic [DISPATCH_WIDTH-1:0]  rob_alloc_en,
    output renamed_instr_t             rob_alloc_instr [DISPATCH_WIDTH],
    output logic                       rob_store_checkpoint,
    output logic                       illegal_fu,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    renamed_instr_t mem [DEPTH];
    renamed_instr_t e;
    logic [PW-1:0] head, tail;
    logic [CW-1:0] n_disp;
    logic [NUM_RS-1:0] used;
    logic go, br, enq, head_illegal;

    assign ready_out = rst && count < CW'(DEPTH) && !flush;
    assign enq = valid_in && ready_out;
    assign head_illegal = count != '0 && int'(mem[head].fu_type) >= NUM_RS;

    // Walk candidate slots in order; the first slot that cannot go closes the group.
    always_comb begin
        dispatch_en = '0;
        rob_alloc_en = '0;
        rob_store_checkpoint = 1'b0;
        n_disp = '0;
        used = '0;
        br = 1'b0;
        go = rst && !flush;
        e = mem[head];
        for (int i = 0; i < NUM_RS; i++) dispatch_instr[i] = mem[head];
        for (int i = 0; i < DISPATCH_WIDTH; i++) rob_alloc_instr[i] = mem[head];
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
            e = mem[head + PW'(k)];
            go = go && CW'(k) < count && CW'(k) < rob_free && int'(e.fu_type) < NUM_RS
                 && !rs_full[e.fu_type] && !used[e.fu_type] && !(br && e.is_branch);
            if (go) begin
                dispatch_en[e.fu_type] = 1'b1;
                dispatch_instr[e.fu_type] = e;
                rob_alloc_en[k] = 1'b1;
                rob_alloc_instr[k] = e;
                used[e.fu_type] = 1'b1;
                br = br | e.is_branch;
                n_disp = n_disp + 1'b1;
            end
        end
        rob_store_checkpoint = br;
    end

    always_ff @(posedge clk) begin
        if (enq) mem[tail] <= instr_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head <= '0;
            tail <= '0;
            count <= '0;
            illegal_fu <= 1'b0;
        end else if (flush) begin
            head <= '0;
            tail <= '0;
            count <= '0;
            illegal_fu <= 1'b0;
        end else begin
            head <= head + n_disp[PW-1:0];
            tail <= tail + PW'(enq);
            count <= count + CW'(enq) - n_disp;
            illegal_fu <= illegal_fu | head_illegal;
        end
    end
endmodule

// File: tb/tb_dispatch_queue.sv
// tb_dispatch_queue: directed-vector self-checking bench for dispatch_queue.
module tb_dispatch_queue;
    import dispatch_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    renamed_instr_t instr_in = '0;
    logic valid_in = 1'b0;
    logic ready_out;
    logic flush = 1'b0;
    logic [2:0] rs_full = 3'b000;
    logic [2:0] dispatch_en;
    renamed_instr_t dispatch_instr [3];
    logic [3:0] rob_free = 4'd8;
    logic [1:0] rob_alloc_en;
    renamed_instr_t rob_alloc_instr [2];
    logic rob_store_checkpoint;
    logic illegal_fu;
    logic [3:0] count;

    int checks = 0;
    int failures = 0;

    dispatch_queue dut (
        .clk(clk), .rst(rst), .instr_in(instr_in), .valid_in(valid_in), .ready_out(ready_out),
        .flush(flush), .rs_full(rs_full), .dispatch_en(dispatch_en), .dispatch_instr(dispatch_instr),
        .rob_free(rob_free), .rob_alloc_en(rob_alloc_en), .rob_alloc_instr(rob_alloc_instr),
        .rob_store_checkpoint(rob_store_checkpoint), .illegal_fu(illegal_fu), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic renamed_instr_t mk(input logic [1:0] fu, input logic [4:0] tag);
        renamed_instr_t r;
        r.fu_type = fu;
        r.is_branch = fu == FU_BRANCH;
        r.rob_tag = tag;
        r.payload = 32'hA000_0000 | 32'(tag);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input renamed_instr_t i);
        instr_in = i;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
    endtask

    task automatic outs(input string tag, input logic [2:0] en, input logic [1:0] al, input logic cp);
        check({tag, ".en"}, 32'(dispatch_en), 32'(en));
        check({tag, ".alloc"}, 32'(rob_alloc_en), 32'(al));
        check({tag, ".ckpt"}, 32'(rob_store_checkpoint), 32'(cp));
    endtask

    initial begin
        #2;
        check("rst.ready", 32'(ready_out), 0);
        check("rst.count", 32'(count), 0);
        outs("rst", 3'b000, 2'b00, 1'b0);
        tick();
        rst = 1'b1;
        #1;
        check("rel.ready", 32'(ready_out), 1);

        // ALU, LSU, BRANCH queued, then released: two then one
        rs_full = 3'b111;
        enq(mk(FU_ALU, 5'd1));
        enq(mk(FU_LSU, 5'd2));
        enq(mk(FU_BRANCH, 5'd3));
        check("t1.count", 32'(count), 3);
        rs_full = 3'b000;
        #1;
        outs("t1.c1", 3'b101, 2'b11, 1'b0);
        check("t1.alu_tag", 32'(dispatch_instr[0].rob_tag), 1);
        check("t1.lsu_tag", 32'(dispatch_instr[2].rob_tag), 2);
        check("t1.slot1_tag", 32'(rob_alloc_instr[1].rob_tag), 2);
        tick();
        outs("t1.c2", 3'b010, 2'b01, 1'b1);
        check("t1.br_tag", 32'(dispatch_instr[1].rob_tag), 3);
        tick();
        check("t1.count_end", 32'(count), 0);
        outs("t1.empty", 3'b000, 2'b00, 1'b0);

        // Two ALU: channel conflict, one per cycle
        rs_full = 3'b111;
        enq(mk(FU_ALU, 5'd4));
        enq(mk(FU_ALU, 5'd5));
        rs_full = 3'b000;
        #1;
        outs("t2.c1", 3'b001, 2'b01, 1'b0);
        check("t2.tag1", 32'(rob_alloc_instr[0].rob_tag), 4);
        tick();
        outs("t2.c2", 3'b001, 2'b01, 1'b0);
        check("t2.tag2", 32'(rob_alloc_instr[0].rob_tag), 5);
        tick();
        check("t2.count_end", 32'(count), 0);

        // Fill 8 (head now at 5), release, wrap 7->0
        rs_full = 3'b111;
        for (int i = 0; i < 8; i++) enq(mk(i % 2 == 0 ? FU_ALU : FU_LSU, 5'(10 + i)));
        check("t3.count_full", 32'(count), 8);
        check("t3.ready_full", 32'(ready_out), 0);
        rs_full = 3'b000;
        #1;
        outs("t3.c1", 3'b101, 2'b11, 1'b0);
        check("t3.ready_disp", 32'(ready_out), 0);
        check("t3.c1_tag0", 32'(rob_alloc_instr[0].rob_tag), 10);
        tick();
        check("t3.ready_after", 32'(ready_out), 1);
        check("t3.count6", 32'(count), 6);
        check("t3.wrap_tag0", 32'(rob_alloc_instr[0].rob_tag), 12);
        check("t3.wrap_tag1", 32'(rob_alloc_instr[1].rob_tag), 13);
        tick();
        check("t3.c3_tag0", 32'(rob_alloc_instr[0].rob_tag), 14);
        tick();
        check("t3.c4_tag1", 32'(rob_alloc_instr[1].rob_tag), 17);
        tick();
        check("t3.count_end", 32'(count), 0);

        // ROB free-count backpressure
        rs_full = 3'b111;
        enq(mk(FU_ALU, 5'd20));
        enq(mk(FU_LSU, 5'd21));
        rs_full = 3'b000;
        rob_free = 4'd0;
        #1;
        outs("t4.rob0", 3'b000, 2'b00, 1'b0);
        rob_free = 4'd1;
        #1;
        outs("t4.rob1", 3'b001, 2'b01, 1'b0);
        tick();
        check("t4.count1", 32'(count), 1);
        rob_free = 4'd8;
        #1;
        outs("t4.rest", 3'b100, 2'b01, 1'b0);
        check("t4.lsu_tag", 32'(dispatch_instr[2].rob_tag), 21);
        tick();

        // Back-to-back branches: one checkpoint per cycle
        rs_full = 3'b111;
        enq(mk(FU_BRANCH, 5'd30));
        enq(mk(FU_BRANCH, 5'd31));
        rs_full = 3'b000;
        #1;
        outs("t5.c1", 3'b010, 2'b01, 1'b1);
        tick();
        outs("t5.c2", 3'b010, 2'b01, 1'b1);
        check("t5.tag2", 32'(dispatch_instr[1].rob_tag), 31);
        tick();
        outs("t5.c3", 3'b000, 2'b00, 1'b0);

        // Enqueue and dispatch in the same cycle: net zero
        enq(mk(FU_ALU, 5'd35));
        check("t6.count1", 32'(count), 1);
        outs("t6.disp", 3'b001, 2'b01, 1'b0);
        enq(mk(FU_LSU, 5'd36));
        check("t6.count_net", 32'(count), 1);
        tick();
        check("t6.count0", 32'(count), 0);

        // Illegal fu_type at head, then flush
        enq(mk(2'd3, 5'd40));
        outs("t7.blocked", 3'b000, 2'b00, 1'b0);
        enq(mk(FU_ALU, 5'd41));
        check("t7.illegal", 32'(illegal_fu), 1);
        check("t7.count", 32'(count), 2);
        outs("t7.behind", 3'b000, 2'b00, 1'b0);
        flush = 1'b1;
        #1;
        check("t7.flush_ready", 32'(ready_out), 0);
        tick();
        flush = 1'b0;
        #1;
        check("t7.flush_count", 32'(count), 0);
        check("t7.flush_illegal", 32'(illegal_fu), 0);
        check("t7.flush_ready_after", 32'(ready_out), 1);

        // Reset mid-operation discards entries at once
        rs_full = 3'b111;
        enq(mk(FU_ALU, 5'd50));
        enq(mk(FU_LSU, 5'd51));
        rs_full = 3'b000;
        #1;
        outs("t8.pre", 3'b101, 2'b11, 1'b0);
        rst = 1'b0;
        #1;
        check("t8.count", 32'(count), 0);
        check("t8.ready", 32'(ready_out), 0);
        outs("t8.rst", 3'b000, 2'b00, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        check("t8.count_after", 32'(count), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
